seg_display_arbiter: RTL
========================

// Module: seg_display_arbiter
// PURPOSE
//   Shares the single 8-digit seven-segment display among NUM_REQ requesters
//   (e.g. PC, ALU result, register probe, debug). Grants the display round-robin.
//   Each owner keeps it for a minimum dwell time. Latches the winner's 32-bit
//   value as 8 hex nibbles and drives the display driver's value input.
// PARAMETERS
//   NUM_REQ   4            number of requesters, 2..8
//   CLK_HZ    100_000_000  clk frequency in Hz
//   DWELL_MS  500          minimum display time per grant in ms; 0 is clamped to 1 cycle
// PORTS
//   clk         in   1            system clock
//   rst_n       in   1            reset, asynchronous, active-low
//   req         in   NUM_REQ      level request, one bit per requester
//   req_data    in   NUM_REQ*32   requester values; requester i uses bits [32i+31:32i]
//   ack         out  NUM_REQ      one-cycle pulse when that requester's data is captured
//   gnt         out  NUM_REQ      one-hot current owner; all-zero before first grant
//   owner_id    out  $clog2(NUM_REQ)  index of current/last owner
//   disp_value  out  8x4          latched nibbles for the display driver; [0] is the rightmost digit
//   disp_valid  out  1            high once any value has been latched
// BEHAVIOUR
//   - Reset values: ack=0, gnt=0, owner_id=0, disp_value=0, disp_valid=0,
//     state=IDLE, dwell counter=0, rr pointer=NUM_REQ-1 (so requester 0 wins first).
//   - DWELL_CYC = max(1, CLK_HZ/1000*DWELL_MS). Counter width is $clog2(DWELL_CYC+1).
//   - FSM states:
//     - IDLE: if |req, pick winner W = first set bit searching from rr_ptr+1 with
//       wrap-around, then go to GRANT. Else stay. disp_value and gnt hold their last values.
//     - GRANT (1 cycle): disp_value<=req_data[W], disp_valid<=1, gnt<=onehot(W),
//       owner_id<=W, ack[W]<=1, rr_ptr<=W, cnt<=0, then go to DWELL.
//       Latency: req rise in IDLE to ack/disp_value update = 2 clocks.
//     - DWELL: cnt increments each cycle. Ownership is held even if req[W] drops.
//       When cnt==DWELL_CYC-1:
//       - if another requester is pending, re-arbitrate from rr_ptr+1 and go to GRANT;
//       - else if req[W] is still high, go to GRANT with W (data refresh, new ack);
//       - else go to IDLE.
//   - Data is sampled only in GRANT. req_data changes during DWELL are not shown
//     until the next grant.
//   - ack is never high for more than 1 cycle per grant, and never for a requester whose req is low.
//   - Simultaneous requests: round-robin order only. No requester waits more than
//     (NUM_REQ-1) dwell periods plus 1 cycle per grant.
//   - rst_n asserted mid-DWELL: all outputs go to their reset values immediately
//     (async). The next grant after release starts at requester 0.
//   - Outputs are registered. No combinational path from req to gnt/ack.
// CONFIGURATION
//   - SEG_ARB_PREEMPT_EN defined:
//     - Requester 0 is high priority. If req[0] rises while another owner is in
//       DWELL, the dwell is aborted and the FSM goes to GRANT for 0 on the next cycle.
//     - rr_ptr is not advanced by a preemptive grant. The round-robin order resumes
//       after the requester that was preempted.
//   - Not defined: no preemption; all requesters are equal.
// STRUCTURE
//   - Package seg_disp_pkg holds:
//     - CLKS_PER_MS = 100_000 at the default CLK_HZ;
//     - typedef logic [7:0][3:0] seg_nibbles_t;
//     - typedef enum logic [1:0] {IDLE, GRANT, DWELL} seg_arb_state_t.
//     seven-seg drivers share this package.
//   - Sub-module seg_rr_pick is combinational: inputs req and ptr; outputs a one-hot
//     winner and a valid flag. It is instantiated once.
// TESTING (CLK_HZ=1000, DWELL_MS=4, so DWELL_CYC=4)
//   1. Request and reset:
//      - reset, then req=4'b0010, req_data[1]=32'h1234_ABCD;
//      - ack[1] pulses at +2 clocks; disp_value=32'h1234_ABCD; gnt=4'b0010; owner_id=1.
//   2. Rotation:
//      - req=4'b1111 held;
//      - grant order is 0,1,2,3,0; consecutive GRANTs are 5 cycles apart (1 GRANT + 4 DWELL).
//   3. Early drop:
//      - owner 2 drops req at DWELL cycle 1 with no others pending;
//      - gnt stays 4'b0100 until the dwell ends, then IDLE; disp_value unchanged; disp_valid=1.
//   4. Refresh:
//      - only req[3] held while req_data[3] changes from 32'h0 to 32'h5 mid-dwell;
//      - disp shows 0 until the next GRANT, then 5; a second ack[3] pulse occurs.
//   5. Reset mid-operation:
//      - rst_n low during DWELL;
//      - gnt=0, disp_valid=0, ack=0 in the same cycle; after release with req=4'b1001,
//        requester 0 is granted first.
//   6. Preemption (SEG_ARB_PREEMPT_EN only):
//      - owner 2 at DWELL cycle 1 and req[0] rises;
//      - GRANT for 0 on the next cycle; the following grant goes to 3 if pending.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and constants for the seven-segment display blocks.
package seg_disp_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 32'd100_000_000;
    localparam int unsigned CLKS_PER_MS    = DEFAULT_CLK_HZ / 32'd1000;

    typedef logic [7:0][3:0] seg_nibbles_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DWELL = 2'd2
    } seg_arb_state_t;

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, with wrap-around.
module seg_rr_pick #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] winner,
    output logic         valid
);

    logic         found_s;
    logic [W-1:0] sel_s;

    // Scan N positions starting just after ptr; the first request seen wins.
    always_comb begin
        winner  = '0;
        found_s = 1'b0;
        sel_s   = '0;
        for (int k = 1; k <= int'(N); k++) begin
            sel_s         = W'((int'(ptr) + k) % int'(N));
            winner[sel_s] = winner[sel_s] | (~found_s & req[sel_s]);
            found_s       = found_s | req[sel_s];
        end
        valid = |req;
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 8-digit display with a minimum dwell per grant.
// Optional requester-0 preemption is enabled by defining SEG_ARB_PREEMPT_EN.
module seg_display_arbiter
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned DWELL_MS = 500
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*32-1:0]      req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output seg_nibbles_t               disp_value,
    output logic                       disp_valid
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQ);
    localparam int unsigned DWELL_RAW = (CLK_HZ / 32'd1000) * DWELL_MS;
    localparam int unsigned DWELL_CYC = (DWELL_RAW == 32'd0) ? 32'd1 : DWELL_RAW;
    localparam int unsigned CNT_W     = $clog2(DWELL_CYC + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 32'd1);

    seg_arb_state_t     state_r, state_nxt_s;
    logic [IDX_W-1:0]   win_idx_r, win_nxt_s;
    logic               pre_r, pre_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [NUM_REQ-1:0] ack_r, gnt_r;
    logic [IDX_W-1:0]   owner_r;
    seg_nibbles_t       disp_r;
    logic               valid_r;

    logic [NUM_REQ-1:0] win_oh_s;
    logic               win_vld_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [NUM_REQ-1:0] grant_oh_s;
    logic [31:0]        data_sel_s;
    logic               rise0_s;

    seg_rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_r),
        .winner (win_oh_s),
        .valid  (win_vld_s)
    );

`ifdef SEG_ARB_PREEMPT_EN
    logic req0_d_r;

    // Delayed copy of req[0] for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req0_d_r <= 1'b0;
        end else begin
            req0_d_r <= req[0];
        end
    end

    assign rise0_s = req[0] & ~req0_d_r;
`else
    assign rise0_s = 1'b0;
`endif

    // Winner index, its one-hot form and the selected requester word.
    always_comb begin
        pick_idx_s = '0;
        data_sel_s = 32'd0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pick_idx_s = pick_idx_s | (win_oh_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
            data_sel_s = data_sel_s |
                         ((win_idx_r == IDX_W'(i)) ? req_data[i*32 +: 32] : 32'd0);
        end
        grant_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_r;
    end

    // State register plus the pending winner and its preemption flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            win_idx_r <= '0;
            pre_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            win_idx_r <= win_nxt_s;
            pre_r     <= pre_nxt_s;
        end
    end

    // Next-state logic; a preemptive grant is flagged so rr_ptr is left alone.
    always_comb begin
        state_nxt_s = state_r;
        win_nxt_s   = win_idx_r;
        pre_nxt_s   = pre_r;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    state_nxt_s = GRANT;
                    win_nxt_s   = pick_idx_s;
                    pre_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            GRANT: begin
                state_nxt_s = DWELL;
            end
            DWELL: begin
                if (rise0_s && (owner_r != {IDX_W{1'b0}})) begin
                    state_nxt_s = GRANT;
                    win_nxt_s   = '0;
                    pre_nxt_s   = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    // The current owner sits last in the search order, so any
                    // other pending requester wins before a refresh of the owner.
                    if (win_vld_s) begin
                        state_nxt_s = GRANT;
                        win_nxt_s   = pick_idx_s;
                        pre_nxt_s   = 1'b0;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = DWELL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Registered outputs, dwell counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r    <= '0;
            gnt_r    <= '0;
            owner_r  <= '0;
            disp_r   <= '0;
            valid_r  <= 1'b0;
            cnt_r    <= '0;
            rr_ptr_r <= IDX_W'(NUM_REQ - 1);
        end else begin
            ack_r <= '0;
            case (state_r)
                GRANT: begin
                    disp_r   <= data_sel_s;
                    valid_r  <= 1'b1;
                    gnt_r    <= grant_oh_s;
                    owner_r  <= win_idx_r;
                    ack_r    <= grant_oh_s & req;
                    rr_ptr_r <= pre_r ? rr_ptr_r : win_idx_r;
                    cnt_r    <= '0;
                end
                DWELL: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign ack        = ack_r;
    assign gnt        = gnt_r;
    assign owner_id   = owner_r;
    assign disp_value = disp_r;
    assign disp_valid = valid_r;

endmodule
